// File: rtl/tx_unit.sv
// ---------------------------------------------------------------------------
// tx_unit: MiniUart transmitter. Holds one byte from the CPU bus and sends it
// as an 8N1 frame (start 0, eight data bits LSB first, stop 1) on txd. Each
// serial bit lasts TICKS_PER_BIT en_tx ticks. If a byte is already waiting
// when a stop bit ends, the next frame starts with no idle gap.
//
// Ports
//   clk    system clock
//   rst    asynchronous active-high reset
//   en_tx  single-cycle enable tick (8x baud); the FSM advances only on it
//   d_in   byte to transmit
//   load   write strobe, captures d_in when the holding register is empty
//   txd    registered serial output, idles high
//   ts     1 = holding register empty (a write is accepted)
//   busy   1 while a frame is on the line
//   irq    one-clk pulse at the end of every stop bit
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | line idle (txd=1); waits for a tick with the holding reg full
// START | start bit (txd=0); the transfer tick counts as its tick 0
// DATA  | eight data bits, shifter shifts right at each bit boundary
// STOP  | stop bit (txd=1); pulses irq and chains the next byte if any
// ---------------------------------------------------------------------------
module tx_unit #(
    parameter int TICKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_tx,
    input  logic [7:0] d_in,
    input  logic       load,
    output logic       txd,
    output logic       ts,
    output logic       busy,
    output logic       irq
);

    localparam int CW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    thr_q, thr_d;
    logic          thr_full_q, thr_full_d;
    logic [7:0]    shift_q, shift_d;
    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          txd_q, txd_d;
    logic          irq_q, irq_d;
    logic          bit_end;

    assign bit_end = (tick_cnt_q == TICK_LAST);

    always_comb begin
        state_d    = state_q;
        thr_d      = thr_q;
        thr_full_d = thr_full_q;
        shift_d    = shift_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        txd_d      = txd_q;
        irq_d      = 1'b0;

        // Acceptance looks at the registered flag only, so a load in the
        // same cycle as a transfer out of thr is dropped (the transfer
        // below only fires when thr_full_q is already set).
        if (load && !thr_full_q) begin
            thr_d      = d_in;
            thr_full_d = 1'b1;
        end

        if (en_tx) begin
            case (state_q)
                IDLE: begin
                    txd_d = 1'b1;
                    if (thr_full_q) begin
                        shift_d    = thr_q;
                        thr_full_d = 1'b0;
                        tick_cnt_d = '0;
                        txd_d      = 1'b0;
                        state_d    = START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = 3'd0;
                        txd_d      = shift_q[0];
                        state_d    = DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        tick_cnt_d = '0;
                        if (bit_cnt_q == 3'd7) begin
                            txd_d   = 1'b1;
                            state_d = STOP;
                        end else begin
                            shift_d   = {1'b0, shift_q[7:1]};
                            txd_d     = shift_q[1];
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + CW'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        irq_d      = 1'b1;
                        tick_cnt_d = '0;
                        if (thr_full_q) begin
                            // Back-to-back: the next start bit begins on
                            // this very boundary.
                            shift_d    = thr_q;
                            thr_full_d = 1'b0;
                            txd_d      = 1'b0;
                            state_d    = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + CW'(1);
                    end
                end
                default: begin
                    txd_d   = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            thr_q      <= 8'h00;
            thr_full_q <= 1'b0;
            shift_q    <= 8'h00;
            tick_cnt_q <= '0;
            bit_cnt_q  <= 3'd0;
            txd_q      <= 1'b1;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            thr_q      <= thr_d;
            thr_full_q <= thr_full_d;
            shift_q    <= shift_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            txd_q      <= txd_d;
            irq_q      <= irq_d;
        end
    end

    assign txd  = txd_q;
    assign ts   = ~thr_full_q;
    assign busy = (state_q != IDLE);
    assign irq  = irq_q;

endmodule

// File: tb/tb_tx_unit.sv
module tb_tx_unit;
    localparam int TPB = 8;
    localparam int FRAME = 10 * TPB;

    logic       clk;
    logic       rst, en_tx, load;
    logic [7:0] d_in;
    logic       txd, ts, busy, irq;

    logic       rst16, en16, load16;
    logic [7:0] d16;
    logic       txd16, ts16, busy16, irq16;

    tx_unit #(.TICKS_PER_BIT(TPB)) dut (
        .clk(clk), .rst(rst), .en_tx(en_tx), .d_in(d_in), .load(load),
        .txd(txd), .ts(ts), .busy(busy), .irq(irq)
    );

    tx_unit #(.TICKS_PER_BIT(16)) dut16 (
        .clk(clk), .rst(rst16), .en_tx(en16), .d_in(d16), .load(load16),
        .txd(txd16), .ts(ts16), .busy(busy16), .irq(irq16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a holding-register flag plus the tick position in
    // the current frame (-1 when the line is idle).
    logic [7:0] exp_q[$];
    logic [7:0] sent_q[$];
    int         irq_tick_q[$];
    bit         m_full = 0;
    int         m_pos = -1;
    int         ticks = 0;
    int         ph = 0;
    int         busy_cnt = 0;
    int         frames = 0;
    int         b2b = 0;
    int         dur_last[10];

    task automatic step(input bit en, input bit ld, input logic [7:0] d);
        bit full_pre;
        bit irq_e;
        en_tx = en;
        load  = ld;
        d_in  = d;
        @(posedge clk);
        irq_e    = 0;
        full_pre = m_full;
        if (!rst) begin
            if (en) begin
                ticks++;
                if (m_pos < 0) begin
                    if (full_pre) begin
                        m_pos  = 0;
                        m_full = 0;
                    end
                end else begin
                    m_pos++;
                    if (m_pos == FRAME) begin
                        irq_e = 1;
                        irq_tick_q.push_back(ticks);
                        if (full_pre) begin
                            m_pos  = 0;
                            m_full = 0;
                        end else begin
                            m_pos = -1;
                        end
                    end
                end
            end
            if (ld && !full_pre) begin
                m_full = 1;
                exp_q.push_back(d);
            end
        end
        #1;
        chk("ts", ts, !m_full);
        chk("busy", busy, (m_pos >= 0));
        chk("irq", irq, irq_e);
        if (m_pos < 0 && !rst) chk("txd_idle", txd, 1);
        if (busy) busy_cnt++;
    endtask

    // en_tx every 4 clk
    task automatic tickclk(input bit ld, input logic [7:0] d);
        step((ph % 4) == 0, ld, d);
        ph++;
    endtask

    task automatic drain();
        int n = 0;
        while ((m_pos >= 0 || m_full) && n < 4000) begin
            tickclk(0, 8'h00);
            n++;
        end
        chk("drain_timeout", (n < 4000), 1);
        repeat (4) tickclk(0, 8'h00);
    endtask

    task automatic wait_ts();
        int n = 0;
        while (!ts && n < 1000) begin
            tickclk(0, 8'h00);
            n++;
        end
        chk("wait_ts_timeout", (n < 1000), 1);
    endtask

    task automatic wait_pos(input int p);
        int n = 0;
        while (m_pos != p && n < 2000) begin
            tickclk(0, 8'h00);
            n++;
        end
        chk("wait_pos_timeout", (n < 2000), 1);
    endtask

    // Monitor: decodes txd in tick time and compares against the queue.
    initial begin : monitor
        int         c;
        int         k;
        int         bad;
        bit         in_fr;
        bit         en_last;
        logic [9:0] pat;
        logic [9:0] cap;
        logic [7:0] b;
        int         dur[10];
        c = 0; bad = 0; in_fr = 0; en_last = 0; pat = '0; cap = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_fr   = 0;
                en_last = 0;
            end else begin
                if (in_fr) begin
                    if (en_last) c++;
                    if (c == FRAME) begin
                        chk("frame_bits", cap, pat);
                        chk("frame_hold", bad, 0);
                        chk("frame_irq", irq, 1);
                        sent_q.push_back(cap[8:1]);
                        frames++;
                        for (int i = 0; i < 10; i++) dur_last[i] = dur[i];
                        in_fr = 0;
                        if (txd === 1'b0) b2b++;
                    end else begin
                        k = c / TPB;
                        if (txd !== pat[k]) bad++;
                        if ((c % TPB) == TPB / 2) cap[k] = txd;
                        dur[k]++;
                    end
                end
                if (!in_fr && txd === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        chk("frame_unexpected", 1, 0);
                        b = 8'h00;
                    end else begin
                        b = exp_q.pop_front();
                    end
                    pat   = {1'b1, b, 1'b0};
                    cap   = '0;
                    c     = 0;
                    bad   = 0;
                    in_fr = 1;
                    for (int i = 0; i < 10; i++) dur[i] = 0;
                    dur[0] = 1;
                end
                en_last = en_tx;
            end
        end
    end

    initial begin : stim
        int f0, b0, lo, hi, n;
        rst = 0; rst16 = 0; en_tx = 0; load = 0; d_in = 0;
        en16 = 0; load16 = 0; d16 = 0;
        #1;
        rst = 1; rst16 = 1;
        #1;
        chk("rst_txd", txd, 1);
        chk("rst_ts", ts, 1);
        chk("rst_busy", busy, 0);
        chk("rst_irq", irq, 0);
        chk("rst16_txd", txd16, 1);
        @(posedge clk);
        #1;
        rst = 0; rst16 = 0;

        // single byte
        f0 = frames; busy_cnt = 0;
        tickclk(1, 8'h55);
        drain();
        chk("single_frames", frames - f0, 1);
        chk("single_byte", sent_q[$], 8'h55);
        chk("single_busy_clk", busy_cnt, 320);
        chk("single_bit_clk", dur_last[5], 32);

        // back-to-back
        f0 = frames; b0 = b2b; busy_cnt = 0;
        tickclk(1, 8'hA5);
        wait_ts();
        tickclk(1, 8'h3C);
        drain();
        chk("b2b_frames", frames - f0, 2);
        chk("b2b_first", sent_q[$-1], 8'hA5);
        chk("b2b_second", sent_q[$], 8'h3C);
        chk("b2b_nogap", b2b - b0, 1);
        chk("b2b_irq_spacing", irq_tick_q[$] - irq_tick_q[$-1], FRAME);
        chk("b2b_busy_clk", busy_cnt, 640);

        // overrun
        f0 = frames;
        tickclk(1, 8'h11);
        wait_ts();
        tickclk(1, 8'h22);
        repeat (3) tickclk(0, 8'h00);
        chk("ovr_ts_at_33", ts, 0);
        tickclk(1, 8'h33);
        drain();
        chk("ovr_frames", frames - f0, 2);
        chk("ovr_first", sent_q[$-1], 8'h11);
        chk("ovr_second", sent_q[$], 8'h22);

        // stall in data bit 3
        tickclk(1, 8'hF0);
        wait_pos(4 * TPB + TPB / 2);
        repeat (50) step(0, 0, 8'h00);
        drain();
        chk("stall_byte", sent_q[$], 8'hF0);
        chk("stall_bit3_clk", dur_last[4], 32 + 50);

        // reset mid-frame with a byte pending
        f0 = frames;
        tickclk(1, 8'h96);
        wait_pos(5 * TPB + TPB / 2);
        tickclk(1, 8'h69);
        chk("rst_pending", ts, 0);
        rst = 1;
        #1;
        chk("arst_txd", txd, 1);
        chk("arst_ts", ts, 1);
        chk("arst_busy", busy, 0);
        chk("arst_irq", irq, 0);
        m_full = 0; m_pos = -1; exp_q.delete();
        repeat (3) step(1, 0, 8'h00);
        rst = 0;
        repeat (400) tickclk(0, 8'h00);
        chk("rst_no_frame", frames - f0, 0);

        // randomized traffic
        f0 = frames;
        for (int i = 0; i < 6000; i++)
            step($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, 8'($urandom));
        drain();
        chk("rand_queue_empty", exp_q.size(), 0);
        chk("rand_some_frames", (frames - f0) > 5, 1);

        // TICKS_PER_BIT=16, en_tx every clk
        en16 = 1; load16 = 1; d16 = 8'h00;
        @(posedge clk); #1;
        load16 = 0;
        @(posedge clk); #1;
        chk("t16_start", txd16, 0);
        chk("t16_busy", busy16, 1);
        lo = 0; hi = 0; n = 0;
        while (txd16 == 1'b0 && n < 400) begin
            lo++; n++;
            @(posedge clk); #1;
        end
        chk("t16_low_clk", lo, 144);
        while (irq16 == 1'b0 && n < 400) begin
            hi++; n++;
            chk("t16_stop_level", txd16, 1);
            @(posedge clk); #1;
        end
        chk("t16_stop_clk", hi, 16);
        chk("t16_end_busy", busy16, 0);
        @(posedge clk); #1;
        chk("t16_irq_pulse", irq16, 0);
        en16 = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tx_unit.md
# tx_unit

Serial transmitting unit of the MiniUart, the counterpart of the receive unit. It accepts a byte from the CPU bus into a one-byte holding register and shifts it out on TxD as one 8N1 frame: one start bit (0), eight data bits LSB first, one stop bit (1). It is driven by the same 8x-baud enable tick as the receiver, so each bit lasts TICKS_PER_BIT ticks. It reports holding-register status and pulses an interrupt at the end of every frame.

## Interface
- TICKS_PER_BIT, default 8: number of en_tx ticks per serial bit. Matches the receiver's 8x oversampling.
- clk  input  1  system clock; all state changes on the posedge.
- rst  input  1  asynchronous, active-high reset.
- en_tx  input  1  single-cycle enable tick at 8x baud; the FSM advances only on cycles where en_tx=1.
- d_in  input  8  byte to transmit.
- load  input  1  write strobe; captures d_in into the holding register.
- txd  output  1  serial output (TxD); registered; idle level 1.
- ts  output  1  transmit status: 1 = holding register empty, so a write is accepted.
- busy  output  1  1 while a frame is on the line (FSM not IDLE).
- irq  output  1  one-clk pulse at the end of each frame's stop bit.

## Operation
- **Reset values** (all asynchronous):
  - txd=1, ts=1, busy=0, irq=0.
  - FSM=IDLE; holding-register full flag thr_full=0.
  - Tick counter and bit counter = 0; holding and shift registers = 0.
- **Holding register:**
  - load=1 with thr_full=0: thr<=d_in and thr_full<=1.
  - load=1 with thr_full=1: ignored. The byte is dropped and no state changes.
  - Acceptance uses the registered thr_full. A load in the same cycle as a transfer out of thr is therefore ignored.
  - ts = ~thr_full.
- **FSM states:** IDLE, START, DATA, STOP. All transitions happen only on en_tx=1 cycles. When en_tx=0, every register holds (frame stretches; txd is held).
  - **IDLE:** txd=1. On a tick with thr_full=1: shifter<=thr, thr_full<=0, tick_cnt<=0, txd<=0, go to START.
  - **START:** txd=0. The state lasts TICKS_PER_BIT ticks, counting the transfer tick as tick 0. On tick TICKS_PER_BIT-1 → DATA, bit_cnt<=0, txd<=shifter[0].
  - **DATA:** each bit lasts TICKS_PER_BIT ticks. At the end of each bit, shifter shifts right and txd<=next bit. After bit 7 → STOP with txd<=1.
  - **STOP:** txd=1 for TICKS_PER_BIT ticks. On the final tick, irq<=1 for one clk, then:
    - if thr_full=1: reload the shifter from thr, clear thr_full, txd<=0, go to START (back-to-back, no idle gap);
    - otherwise go to IDLE.
  - Any undefined encoding → IDLE with txd<=1.
- **Other behaviour:**
  - busy = (FSM != IDLE).
  - irq is a pulse, not sticky.
  - A reset asserted mid-frame aborts the frame immediately: txd=1 and the pending byte is lost.

## Timing
- Frame length is 10×TICKS_PER_BIT en_tx ticks (80 at the default).
- Bit boundaries: txd changes in the clk after tick k×TICKS_PER_BIT of the frame, for k=0..9. Tick 0 is the IDLE→START transfer tick.
- load in cycle n → ts=0 from cycle n+1.
- Transfer tick in cycle m → ts=1 and busy=1 from cycle m+1. A load in cycle m+1 is accepted.
- Stop-bit end tick in cycle p → irq=1 in cycle p+1 only.
- Back-to-back frames: the next start bit begins at that same boundary, so txd goes low in cycle p+1.
- Maximum latency from load to start bit, with the unit idle: the next en_tx tick plus 1 clk.

## Test plan
- **Single byte:** en_tx every 4 clk; load 0x55 in idle. → txd sequence 0,1,0,1,0,1,0,1,0,1, each level lasting 32 clk; busy high for 320 clk; one irq pulse; ts=1 again 1 clk after the transfer tick.
- **Back-to-back:** load 0xA5, then load 0x3C as soon as ts=1. → bits 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0; no idle gap between the stop and start bits; 2 irq pulses 80 ticks apart; busy stays high throughout.
- **Overrun:** load 0x11, then load 0x22 and 0x33 while ts=0. → the frames carry 0x11 then 0x22; 0x33 is never sent; ts=0 when 0x33's load is issued.
- **Stall:** hold en_tx=0 for 50 clk in the middle of data bit 3 of 0xF0. → txd holds its level; the bit is stretched by exactly 50 clk; the final waveform is still 0xF0 LSB first.
- **Reset mid-frame:** assert rst during data bit 4 with a byte pending in thr. → txd=1, ts=1, busy=0, irq=0 asynchronously; after deassertion no frame is sent until the next load.
- **Tick ratio:** TICKS_PER_BIT=16, en_tx every clk, load 0x00. → start + 8 data bits hold txd low for 144 clk, followed by a 16-clk stop bit.
